// File: rtl/alu_ctrl_pkg.sv
// ALU-control shared definitions: control codes, ALUOp encodings, LEGv8 opcodes, decode function.
// Latency: n/a (package, purely combinational helpers).
// Backpressure: n/a.
package alu_ctrl_pkg;

  localparam int OPC_W  = 11;
  localparam int CODE_W = 4;

  // ALU control codes
  localparam logic [CODE_W-1:0] ALU_AND    = 4'b0000;
  localparam logic [CODE_W-1:0] ALU_OR     = 4'b0001;
  localparam logic [CODE_W-1:0] ALU_ADD    = 4'b0010;
  localparam logic [CODE_W-1:0] ALU_EOR    = 4'b0011;
  localparam logic [CODE_W-1:0] ALU_LSL    = 4'b0100;
  localparam logic [CODE_W-1:0] ALU_LSR    = 4'b0101;
  localparam logic [CODE_W-1:0] ALU_SUB    = 4'b0110;
  localparam logic [CODE_W-1:0] ALU_PASS_B = 4'b0111;
  localparam logic [CODE_W-1:0] ALU_MUL    = 4'b1000;
  localparam logic [CODE_W-1:0] ALU_SDIV   = 4'b1001;
  localparam logic [CODE_W-1:0] ALU_UDIV   = 4'b1010;
  localparam logic [CODE_W-1:0] ALU_NOR    = 4'b1100;

  // ALUOp encodings from main control
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  // LEGv8 R-format opcodes (instruction[31:21])
  localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_EOR  = 11'b11001010000;
  localparam logic [OPC_W-1:0] OP_LSL  = 11'b11010011011;
  localparam logic [OPC_W-1:0] OP_LSR  = 11'b11010011010;
  localparam logic [OPC_W-1:0] OP_MUL  = 11'b10011011000;
  localparam logic [OPC_W-1:0] OP_SDIV = 11'b10011010110;
  localparam logic [OPC_W-1:0] OP_UDIV = 11'b10011010111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic              illegal;
    logic              is_multi;
    logic [CODE_W-1:0] code;
  } dec_t;

  // Illegal decodes fall back to ADD so downstream always sees a harmless op.
  function automatic dec_t decode_alu(input logic [OPC_W-1:0] opcode, input logic [1:0] aluop);
    dec_t d;
    d.illegal  = 1'b0;
    d.is_multi = 1'b0;
    d.code     = ALU_ADD;
    case (aluop)
      ALUOP_MEM:    d.code = ALU_ADD;
      ALUOP_BRANCH: d.code = ALU_PASS_B;
      ALUOP_RTYPE: begin
        // SDIV and UDIV differ only in the lowest opcode bit
        if (opcode[OPC_W-1:1] == OP_SDIV[OPC_W-1:1]) begin
          d.is_multi = 1'b1;
          d.code     = opcode[0] ? ALU_UDIV : ALU_SDIV;
        end else begin
          case (opcode)
            OP_ADD:  d.code = ALU_ADD;
            OP_SUB:  d.code = ALU_SUB;
            OP_AND:  d.code = ALU_AND;
            OP_ORR:  d.code = ALU_OR;
            OP_EOR:  d.code = ALU_EOR;
            OP_LSL:  d.code = ALU_LSL;
            OP_LSR:  d.code = ALU_LSR;
            OP_MUL: begin
              d.code     = ALU_MUL;
              d.is_multi = 1'b1;
            end
            default: d.illegal = 1'b1;
          endcase
        end
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decoder; reusable by the legacy single-cycle path.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [1:0]        aluop,
  output logic              illegal,
  output logic              is_multi,
  output logic [CODE_W-1:0] code
);

  dec_t dec;

  // Decode opcode/aluop into control code plus qualifiers
  always_comb begin
    dec      = decode_alu(opcode, aluop);
    illegal  = dec.illegal;
    is_multi = dec.is_multi;
    code     = dec.code;
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decoder with multi-cycle MUL/DIV sequencing, illegal detection and flush.
// Latency: 1 cycle from accept to out_valid; multi-cycle ops hold busy for MUL_LAT/DIV_LAT cycles.
// Backpressure: in_ready low while busy; flush cancels any pending/executing op and blocks accept.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [1:0]          aluop,
  output logic                out_valid,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic                illegal,
  output logic                busy,
  output logic                done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               ready_en;
  logic               accept;
  logic               dec_illegal;
  logic               dec_multi;
  logic [CODE_W-1:0]  dec_code;
  logic               start_multi;
  logic [CNT_W-1:0]   cnt_load;

  alu_ctrl_decode u_decode (
    .opcode   (opcode),
    .aluop    (aluop),
    .illegal  (dec_illegal),
    .is_multi (dec_multi),
    .code     (dec_code)
  );

  // flush deliberately does not gate in_ready; it only blocks the accept internally
  assign accept      = in_valid & in_ready & ~flush;
  assign start_multi = accept & dec_multi & ~dec_illegal;
  assign cnt_load    = (dec_code == ALU_MUL) ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: flush always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_multi) state_nxt = S_BUSY;
        S_BUSY:  if (cnt == '0) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore outputs from state
  always_comb begin
    in_ready = (state == S_IDLE) & ready_en;
    busy     = (state == S_BUSY);
  end

  // ready_en holds in_ready low until the first clock after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // Latency counter: loads LAT-1 on issue, counts down while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           cnt <= '0;
    else if (flush)                      cnt <= '0;
    else if (start_multi)                cnt <= cnt_load;
    else if (state == S_BUSY && cnt != '0) cnt <= cnt - 1'b1;
  end

  // Issue registers: alu_ctrl/illegal hold until the next accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_ctrl  <= CTRL_W'(ALU_ADD);
      illegal   <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= accept;
      done      <= ~flush & (state == S_BUSY) & (cnt == '0);
      if (accept) begin
        alu_ctrl <= CTRL_W'(dec_code);
        illegal  <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] opcode;
  logic [1:0]  aluop;
  logic        out_valid;
  logic [3:0]  alu_ctrl;
  logic        illegal;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  alu_ctrl_seq #(.OPCODE_W(11), .CTRL_W(4), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .aluop     (aluop),
    .out_valid (out_valid),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [10:0] op, input logic [1:0] aop);
    in_valid = v;
    opcode   = op;
    aluop    = aop;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 11'd0, 2'b00);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL rst_alu_ctrl: got %b exp 0010", alu_ctrl); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b exp 0", illegal); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b exp 00", busy, done); end
    reset = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops [4];
    logic [3:0]  exp [4];
    ops[0] = 11'b10001011000; exp[0] = 4'b0010;
    ops[1] = 11'b11001011000; exp[1] = 4'b0110;
    ops[2] = 11'b10001010000; exp[2] = 4'b0000;
    ops[3] = 11'b10101010000; exp[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 2'b10);
      tick();
      checks++; if (out_valid !== 1'b1 || alu_ctrl !== exp[i] || illegal !== 1'b0)
        begin errors++; $display("FAIL b2b_%0d: got v=%b c=%b i=%b exp v=1 c=%b i=0", i, out_valid, alu_ctrl, illegal, exp[i]); end
    end
    drive(1'b0, 11'd0, 2'b00);
    tick();
    checks++; if (out_valid !== 1'b0 || alu_ctrl !== 4'b0001)
      begin errors++; $display("FAIL b2b_hold: got v=%b c=%b exp v=0 c=0001", out_valid, alu_ctrl); end
  endtask

  task automatic test_ext_decode();
    logic [10:0] ops [3];
    logic [3:0]  exp [3];
    ops[0] = 11'b11001010000; exp[0] = 4'b0011;
    ops[1] = 11'b11010011011; exp[1] = 4'b0100;
    ops[2] = 11'b11010011010; exp[2] = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 2'b10);
      tick();
      checks++; if (out_valid !== 1'b1 || alu_ctrl !== exp[i] || busy !== 1'b0)
        begin errors++; $display("FAIL ext_%0d: got v=%b c=%b b=%b exp v=1 c=%b b=0", i, out_valid, alu_ctrl, busy, exp[i]); end
    end
    drive(1'b0, 11'd0, 2'b00);
    tick();
  endtask

  task automatic test_mem_branch();
    drive(1'b1, 11'b11111000010, 2'b00);
    tick();
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b0010 || illegal !== 1'b0)
      begin errors++; $display("FAIL mem: got v=%b c=%b i=%b exp v=1 c=0010 i=0", out_valid, alu_ctrl, illegal); end
    drive(1'b1, 11'b01010101010, 2'b01);
    tick();
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b0111 || illegal !== 1'b0)
      begin errors++; $display("FAIL branch: got v=%b c=%b i=%b exp v=1 c=0111 i=0", out_valid, alu_ctrl, illegal); end
    drive(1'b0, 11'd0, 2'b00);
    tick();
  endtask

  task automatic test_mul();
    drive(1'b1, 11'b10011011000, 2'b10);
    tick();
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b1000)
      begin errors++; $display("FAIL mul_issue: got v=%b c=%b exp v=1 c=1000", out_valid, alu_ctrl); end
    // Keep offering an ADD while busy; it must not be taken
    drive(1'b1, 11'b10001011000, 2'b10);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || alu_ctrl !== 4'b1000)
        begin errors++; $display("FAIL mul_busy_%0d: got b=%b r=%b d=%b c=%b exp b=1 r=0 d=0 c=1000", i, busy, in_ready, done, alu_ctrl); end
      if (i > 1) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_nov_%0d: got %b exp 0", i, out_valid); end
      end
    end
    drive(1'b0, 11'd0, 2'b00);
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL mul_done: got b=%b d=%b r=%b v=%b exp b=0 d=1 r=1 v=0", busy, done, in_ready, out_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b exp 0", done); end
  endtask

  task automatic test_udiv();
    logic bad = 1'b0;
    drive(1'b1, 11'b10011010111, 2'b10);
    tick();
    drive(1'b0, 11'd0, 2'b00);
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b1010 || busy !== 1'b1)
      begin errors++; $display("FAIL udiv_issue: got v=%b c=%b b=%b exp v=1 c=1010 b=1", out_valid, alu_ctrl, busy); end
    for (int i = 2; i <= 32; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL udiv_busy_span: got early end exp 32 busy cycles"); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1)
      begin errors++; $display("FAIL udiv_done: got b=%b d=%b exp b=0 d=1", busy, done); end
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 11'b00000000000, 2'b10);
    tick();
    checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 4'b0010 || busy !== 1'b0)
      begin errors++; $display("FAIL ill_rtype: got v=%b i=%b c=%b b=%b exp v=1 i=1 c=0010 b=0", out_valid, illegal, alu_ctrl, busy); end
    drive(1'b1, 11'b10011011000, 2'b11);
    tick();
    checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 4'b0010 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL ill_rsvd: got v=%b i=%b c=%b b=%b r=%b exp v=1 i=1 c=0010 b=0 r=1", out_valid, illegal, alu_ctrl, busy, in_ready); end
    drive(1'b1, 11'b10001011000, 2'b10);
    tick();
    checks++; if (out_valid !== 1'b1 || illegal !== 1'b0)
      begin errors++; $display("FAIL ill_clear: got v=%b i=%b exp v=1 i=0", out_valid, illegal); end
    drive(1'b0, 11'd0, 2'b00);
    tick();
  endtask

  task automatic test_flush();
    logic saw_done = 1'b0;
    drive(1'b1, 11'b10011010110, 2'b10);
    tick();
    drive(1'b0, 11'd0, 2'b00);
    checks++; if (alu_ctrl !== 4'b1001 || busy !== 1'b1)
      begin errors++; $display("FAIL sdiv_issue: got c=%b b=%b exp c=1001 b=1", alu_ctrl, busy); end
    for (int i = 2; i <= 10; i++) tick();
    // Flush in busy cycle 10, with a competing input that must be dropped
    flush = 1'b1;
    drive(1'b1, 11'b11001011000, 2'b10);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_busy10: got r=%b exp 0", in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 11'd0, 2'b00);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_state: got b=%b d=%b v=%b r=%b exp b=0 d=0 v=0 r=1", busy, done, out_valid, in_ready); end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got done pulse exp none"); end
    // Flush in IDLE blocks a simultaneous accept
    flush = 1'b1;
    drive(1'b1, 11'b11001011000, 2'b10);
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || alu_ctrl !== 4'b1001)
      begin errors++; $display("FAIL flush_idle: got v=%b c=%b exp v=0 c=1001", out_valid, alu_ctrl); end
    drive(1'b1, 11'b10001011000, 2'b10);
    tick();
    drive(1'b0, 11'd0, 2'b00);
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b0010)
      begin errors++; $display("FAIL flush_next_add: got v=%b c=%b exp v=1 c=0010", out_valid, alu_ctrl); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    logic saw_done = 1'b0;
    drive(1'b1, 11'b10011011000, 2'b10);
    tick();
    drive(1'b0, 11'd0, 2'b00);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmb_pre: got b=%b exp 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || alu_ctrl !== 4'b0010 || busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0)
      begin errors++; $display("FAIL rmb_async: got v=%b c=%b b=%b d=%b i=%b exp v=0 c=0010 b=0 d=0 i=0", out_valid, alu_ctrl, busy, done, illegal); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL rmb_after: got sawdone=%b r=%b b=%b exp 0 1 0", saw_done, in_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ext_decode();
    test_mem_branch();
    test_mul();
    test_udiv();
    test_illegal();
    test_flush();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
